// File: rtl/alarm_controller_if.sv
// Keypad/sensor/status bundle for alarm_controller; the controller takes the slave side.
interface alarm_controller_if #(
    parameter int unsigned N_SENSORS = 4
);
    logic [N_SENSORS-1:0] SENSOR_IN;
    logic [N_SENSORS-1:0] BYPASS_IN;
    logic                 KEY_VALID;
    logic                 KEY_OK;
    logic [2:0]           STATE_OUT;
    logic                 SIREN_OUT;
    logic                 ARMED_OUT;
    logic [N_SENSORS-1:0] TRIG_OUT;

    modport master (
        output SENSOR_IN, BYPASS_IN, KEY_VALID, KEY_OK,
        input  STATE_OUT, SIREN_OUT, ARMED_OUT, TRIG_OUT
    );

    modport slave (
        input  SENSOR_IN, BYPASS_IN, KEY_VALID, KEY_OK,
        output STATE_OUT, SIREN_OUT, ARMED_OUT, TRIG_OUT
    );
endinterface

// File: rtl/alarm_controller.sv
// Intruder alarm controller: exit/entry delays, instant/delayed zones, wrong-key lockout.
// Optional macro ALARM_SIREN_TIMEOUT_EN: ALARM times out back to ARMED after SIREN_CYCLES.
module alarm_controller #(
    parameter int unsigned          N_SENSORS    = 4,
    parameter logic [N_SENSORS-1:0] DELAY_MASK   = N_SENSORS'(4'b0010),
    parameter int unsigned          EXIT_CYCLES  = 15000,
    parameter int unsigned          ENTRY_CYCLES = 15000,
    parameter int unsigned          MAX_ERRORS   = 3,
    parameter int unsigned          SIREN_CYCLES = 60000
) (
    input logic              CLK,
    input logic              RST_N,
    alarm_controller_if.slave bus
);

    if (N_SENSORS < 1 || N_SENSORS > 16) begin : g_bad_n
        $error("N_SENSORS out of range");
    end
    if (EXIT_CYCLES < 1 || ENTRY_CYCLES < 1 || SIREN_CYCLES < 1) begin : g_bad_cycles
        $error("cycle parameters must be >= 1");
    end
    if (MAX_ERRORS < 1 || MAX_ERRORS > 7) begin : g_bad_errors
        $error("MAX_ERRORS out of range");
    end

    localparam int unsigned MAX_ED = (EXIT_CYCLES > ENTRY_CYCLES) ? EXIT_CYCLES : ENTRY_CYCLES;
`ifdef ALARM_SIREN_TIMEOUT_EN
    localparam int unsigned MAX_T = (SIREN_CYCLES > MAX_ED) ? SIREN_CYCLES : MAX_ED;
`else
    localparam int unsigned MAX_T = MAX_ED;
`endif
    // Counter holds remaining-cycles-minus-one, so $clog2(MAX_T) bits suffice.
    localparam int unsigned CW = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    typedef enum logic [2:0] {
        DISARMED    = 3'd0,
        EXIT_DELAY  = 3'd1,
        ARMED       = 3'd2,
        ENTRY_DELAY = 3'd3,
        ALARM       = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           err_q, err_d;
    logic [N_SENSORS-1:0] sync1_q, sync1_d;
    logic [N_SENSORS-1:0] sync2_q, sync2_d;
    logic [N_SENSORS-1:0] bypass_q, bypass_d;
    logic [N_SENSORS-1:0] trig_q, trig_d;
    logic                 siren_q, siren_d;
    logic                 armed_q, armed_d;

    logic [N_SENSORS-1:0] active;
    logic                 any_inst;
    logic                 any_del;
    logic                 key_good;
    logic                 key_bad;
    logic                 expired;
    logic [2:0]           err_inc;
    logic                 err_limit;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        bypass_d = bypass_q;
        trig_d   = trig_q;
        sync1_d  = bus.SENSOR_IN;
        sync2_d  = sync1_q;

        active    = sync2_q & ~bypass_q;
        any_inst  = |(active & ~DELAY_MASK);
        any_del   = |(active & DELAY_MASK);
        key_good  = bus.KEY_VALID & bus.KEY_OK;
        key_bad   = bus.KEY_VALID & ~bus.KEY_OK;
        expired   = (cnt_q == '0);
        err_inc   = err_q + 3'd1;
        err_limit = (err_inc >= 3'(MAX_ERRORS));

        case (state_q)
            DISARMED: begin
                if (key_good) begin
                    state_d  = EXIT_DELAY;
                    bypass_d = bus.BYPASS_IN;
                    trig_d   = '0;
                    err_d    = '0;
                end
            end
            EXIT_DELAY: begin
                if (key_good) begin
                    state_d = DISARMED;
                    err_d   = '0;
                end else if (expired) begin
                    state_d = ARMED;
                end
            end
            ARMED, ENTRY_DELAY: begin
                trig_d = trig_q | active;
                if (key_good) begin
                    state_d = DISARMED;
                    err_d   = '0;
                end else begin
                    if (key_bad) begin
                        err_d = err_inc;
                    end
                    if ((state_q == ENTRY_DELAY && expired) || any_inst || (key_bad && err_limit)) begin
                        state_d = ALARM;
                    end else if (state_q == ARMED && any_del) begin
                        state_d = ENTRY_DELAY;
                    end
                end
            end
            ALARM: begin
                trig_d = trig_q | active;
                if (key_good) begin
                    state_d = DISARMED;
                    err_d   = '0;
                end
`ifdef ALARM_SIREN_TIMEOUT_EN
                else if (expired) begin
                    state_d = ARMED;
                    err_d   = '0;
                end
`endif
            end
            default: state_d = DISARMED;
        endcase

        // Shared timer: reloaded only on a state change, otherwise counts down and parks at zero.
        if (state_d != state_q) begin
            case (state_d)
                EXIT_DELAY:  cnt_d = CW'(EXIT_CYCLES - 1);
                ENTRY_DELAY: cnt_d = CW'(ENTRY_CYCLES - 1);
`ifdef ALARM_SIREN_TIMEOUT_EN
                ALARM:       cnt_d = CW'(SIREN_CYCLES - 1);
`endif
                default:     cnt_d = '0;
            endcase
        end else if (!expired) begin
            cnt_d = cnt_q - CW'(1);
        end

        siren_d = (state_d == ALARM);
        armed_d = (state_d != DISARMED);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= DISARMED;
            cnt_q    <= '0;
            err_q    <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            bypass_q <= '0;
            trig_q   <= '0;
            siren_q  <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            bypass_q <= bypass_d;
            trig_q   <= trig_d;
            siren_q  <= siren_d;
            armed_q  <= armed_d;
        end
    end

    assign bus.STATE_OUT = state_q;
    assign bus.SIREN_OUT = siren_q;
    assign bus.ARMED_OUT = armed_q;
    assign bus.TRIG_OUT  = trig_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: directed vector table, corner sequences, random run vs reference model.
`timescale 1ns/1ps
module tb_alarm_controller;

    localparam int EXIT_C  = 6;
    localparam int ENTRY_C = 8;
    localparam int MAXE    = 3;
    localparam int SIREN_C = 20;
    localparam logic [3:0] DMASK = 4'b0010;

    logic CLK = 1'b0;
    logic RST_N;
    int checks = 0;
    int errors = 0;

    alarm_controller_if #(.N_SENSORS(4)) bus();

    alarm_controller #(
        .N_SENSORS(4), .DELAY_MASK(DMASK), .EXIT_CYCLES(EXIT_C),
        .ENTRY_CYCLES(ENTRY_C), .MAX_ERRORS(MAXE), .SIREN_CYCLES(SIREN_C)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .bus(bus)
    );

    always #5 CLK = ~CLK;

    // Reference model: timers are absolute deadlines on an edge counter.
    int         m_state, m_err, m_cyc, m_deadline;
    logic [3:0] m_trig, m_byp;
    logic [3:0] m_hist[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_err = 0; m_trig = '0; m_byp = '0; m_deadline = 0;
        m_hist = {4'h0, 4'h0};
    endtask

    task automatic model_step();
        logic [3:0] eff;
        bit ok, bad, to_alarm;
        eff = m_hist[0] & ~m_byp;
        void'(m_hist.pop_front());
        m_hist.push_back(bus.SENSOR_IN);
        m_cyc++;
        ok  = bus.KEY_VALID && bus.KEY_OK;
        bad = bus.KEY_VALID && !bus.KEY_OK;
        if (m_state >= 2) m_trig |= eff;
        if (ok) begin
            if (m_state == 0) begin
                m_state = 1; m_byp = bus.BYPASS_IN; m_trig = '0;
                m_deadline = m_cyc + EXIT_C;
            end else begin
                m_state = 0;
            end
            m_err = 0;
        end else begin
            case (m_state)
                1: if (m_cyc == m_deadline) m_state = 2;
                2, 3: begin
                    if (bad) m_err++;
                    to_alarm = ((eff & ~DMASK) != 0) || (bad && m_err >= MAXE) ||
                               (m_state == 3 && m_cyc == m_deadline);
                    if (to_alarm) begin
                        m_state = 4; m_deadline = m_cyc + SIREN_C;
                    end else if (m_state == 2 && (eff & DMASK) != 0) begin
                        m_state = 3; m_deadline = m_cyc + ENTRY_C;
                    end
                end
                4: begin
`ifdef ALARM_SIREN_TIMEOUT_EN
                    if (m_cyc == m_deadline) begin
                        m_state = 2; m_err = 0;
                    end
`endif
                end
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1 bus.KEY_VALID = 1'b0;
        @(negedge CLK);
        chk("model_state", bus.STATE_OUT, m_state);
        chk("model_siren", bus.SIREN_OUT, (m_state == 4));
        chk("model_armed", bus.ARMED_OUT, (m_state != 0));
        chk("model_trig",  bus.TRIG_OUT,  m_trig);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic key(input bit good);
        bus.KEY_VALID = 1'b1;
        bus.KEY_OK    = good;
        tick();
    endtask

    // Called at a negedge: asserts reset mid-cycle and checks outputs clear before any clock edge.
    task automatic do_reset(input string nm);
        #2 RST_N = 1'b0;
        #1;
        chk({nm, "_state"}, bus.STATE_OUT, 0);
        chk({nm, "_siren"}, bus.SIREN_OUT, 0);
        chk({nm, "_armed"}, bus.ARMED_OUT, 0);
        chk({nm, "_trig"},  bus.TRIG_OUT,  0);
        @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit         kv;
        bit         kok;
        logic [3:0] sen;
        logic [3:0] byp;
        int         n;
        int         st;
        logic [3:0] trig;
    } vec_t;

    function automatic vec_t v(bit kv, bit kok, logic [3:0] sen, logic [3:0] byp,
                               int n, int st, logic [3:0] trig);
        vec_t r;
        r.kv = kv; r.kok = kok; r.sen = sen; r.byp = byp; r.n = n; r.st = st; r.trig = trig;
        return r;
    endfunction

    vec_t tbl[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // kv kok sensor bypass cycles -> state trig
        tbl.push_back(v(1,1,4'h0,4'h0,1,1,4'h0));  // arm
        tbl.push_back(v(0,0,4'h0,4'h0,5,1,4'h0));
        tbl.push_back(v(0,0,4'h0,4'h0,1,2,4'h0));  // exit delay expires on 6th edge
        tbl.push_back(v(0,0,4'h1,4'h0,2,2,4'h0));  // still in synchroniser
        tbl.push_back(v(0,0,4'h1,4'h0,1,4,4'h1));  // instant zone -> ALARM
        tbl.push_back(v(1,1,4'h0,4'h0,1,0,4'h1));  // disarm, trig sticky
        tbl.push_back(v(1,1,4'h0,4'h0,1,1,4'h0));  // re-arm clears trig
        tbl.push_back(v(0,0,4'h0,4'h0,6,2,4'h0));
        tbl.push_back(v(0,0,4'h2,4'h0,3,3,4'h2));  // door -> ENTRY_DELAY
        tbl.push_back(v(0,0,4'h0,4'h0,4,3,4'h2));
        tbl.push_back(v(1,1,4'h0,4'h0,1,0,4'h2));  // key on 5th entry cycle
        tbl.push_back(v(1,1,4'h0,4'h0,1,1,4'h0));
        tbl.push_back(v(0,0,4'h0,4'h0,6,2,4'h0));
        tbl.push_back(v(0,0,4'h2,4'h0,3,3,4'h2));
        tbl.push_back(v(0,0,4'h0,4'h0,7,3,4'h2));
        tbl.push_back(v(0,0,4'h0,4'h0,1,4,4'h2));  // entry expiry on 8th edge
        tbl.push_back(v(1,1,4'h0,4'h0,1,0,4'h2));
        tbl.push_back(v(1,1,4'h0,4'h0,1,1,4'h0));
        tbl.push_back(v(0,0,4'h0,4'h0,6,2,4'h0));
        tbl.push_back(v(1,0,4'h0,4'h0,1,2,4'h0));  // wrong key 1
        tbl.push_back(v(0,0,4'h0,4'h0,1,2,4'h0));
        tbl.push_back(v(1,0,4'h0,4'h0,1,2,4'h0));  // wrong key 2
        tbl.push_back(v(1,0,4'h0,4'h0,1,4,4'h0));  // wrong key 3 -> ALARM
        tbl.push_back(v(1,1,4'h0,4'h0,1,0,4'h0));
        tbl.push_back(v(1,1,4'h0,4'h0,1,1,4'h0));
        tbl.push_back(v(0,0,4'h0,4'h0,6,2,4'h0));
        tbl.push_back(v(1,0,4'h0,4'h0,1,2,4'h0));
        tbl.push_back(v(1,0,4'h0,4'h0,1,2,4'h0));
        tbl.push_back(v(1,1,4'h0,4'h0,1,0,4'h0));  // correct key clears counter
        tbl.push_back(v(1,1,4'h0,4'h0,1,1,4'h0));
        tbl.push_back(v(0,0,4'h0,4'h0,6,2,4'h0));
        tbl.push_back(v(1,0,4'h0,4'h0,1,2,4'h0));
        tbl.push_back(v(1,0,4'h0,4'h0,1,2,4'h0));
        tbl.push_back(v(1,0,4'h0,4'h0,1,4,4'h0));  // needs full three again
        tbl.push_back(v(1,1,4'h0,4'h0,1,0,4'h0));
        tbl.push_back(v(1,1,4'h0,4'h1,1,1,4'h0));  // arm with sensor 0 bypassed
        tbl.push_back(v(0,0,4'h0,4'h0,6,2,4'h0));
        tbl.push_back(v(0,0,4'h1,4'h0,5,2,4'h0));  // bypassed sensor ignored
        tbl.push_back(v(1,1,4'h0,4'h0,1,0,4'h0));

        RST_N = 1'b0;
        bus.SENSOR_IN = '0; bus.BYPASS_IN = '0; bus.KEY_VALID = 1'b0; bus.KEY_OK = 1'b0;
        m_cyc = 0;
        model_reset();
        #12;
        chk("reset_state", bus.STATE_OUT, 0);
        chk("reset_siren", bus.SIREN_OUT, 0);
        chk("reset_armed", bus.ARMED_OUT, 0);
        chk("reset_trig",  bus.TRIG_OUT,  0);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            bus.SENSOR_IN = tbl[i].sen;
            bus.BYPASS_IN = tbl[i].byp;
            if (tbl[i].kv) begin
                bus.KEY_VALID = 1'b1;
                bus.KEY_OK    = tbl[i].kok;
            end
            run(tbl[i].n);
            chk($sformatf("tbl%0d_state", i), bus.STATE_OUT, tbl[i].st);
            chk($sformatf("tbl%0d_trig", i),  bus.TRIG_OUT,  tbl[i].trig);
        end

        // Entry-delay expiry on the same edge as a correct key: key wins.
        key(1); run(EXIT_C);
        bus.SENSOR_IN = 4'h2; run(3);
        chk("coinc_entry", bus.STATE_OUT, 3);
        bus.SENSOR_IN = 4'h0; run(ENTRY_C - 1);
        key(1);
        chk("coinc_state", bus.STATE_OUT, 0);
        chk("coinc_siren", bus.SIREN_OUT, 0);

        // Asynchronous reset in ALARM, then sensors alone cannot leave DISARMED.
        key(1); run(EXIT_C);
        bus.SENSOR_IN = 4'h1; run(3);
        chk("rst_alarm_siren", bus.SIREN_OUT, 1);
        do_reset("rst_async");
        run(10);
        chk("rst_post_state", bus.STATE_OUT, 0);
        bus.SENSOR_IN = 4'h0; run(3);

        // Siren timeout behaviour.
        key(1); run(EXIT_C);
        bus.SENSOR_IN = 4'h1; run(3);
        chk("to_alarm", bus.STATE_OUT, 4);
        bus.SENSOR_IN = 4'h0;
`ifdef ALARM_SIREN_TIMEOUT_EN
        run(SIREN_C - 1);
        chk("to_before", bus.STATE_OUT, 4);
        run(1);
        chk("to_state", bus.STATE_OUT, 2);
        chk("to_trig",  bus.TRIG_OUT,  4'h1);
`else
        run(120);
        chk("hold_state", bus.STATE_OUT, 4);
        chk("hold_siren", bus.SIREN_OUT, 1);
`endif
        key(1);
        chk("to_disarm", bus.STATE_OUT, 0);

        // Random run against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0)
                bus.SENSOR_IN = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            bus.BYPASS_IN = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                bus.KEY_VALID = 1'b1;
                bus.KEY_OK    = ($urandom_range(0, 2) != 0);
            end
            if ($urandom_range(0, 499) == 0) begin
                bus.KEY_VALID = 1'b0;
                do_reset("rnd_reset");
            end else begin
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
